// File: rtl/wb2axi.sv
// wb2axi: Wishbone classic slave to AXI4 master bridge.
// Each Wishbone cycle becomes one single-beat AXI transaction; one outstanding.
module wb2axi #(
    parameter int ID_WIDTH       = 10,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID         = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          wb_cyc_i,
    input  logic                          wb_stb_i,
    input  logic                          wb_we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     wb_adr_i,
    input  logic [AXI_DATA_WIDTH-1:0]     wb_dat_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   wb_sel_i,
    output logic [AXI_DATA_WIDTH-1:0]     wb_dat_o,
    output logic                          wb_ack_o,
    output logic                          wb_err_o,
    output logic [ID_WIDTH-1:0]           master_aw_id,
    output logic [AXI_ADDR_WIDTH-1:0]     master_aw_addr,
    output logic [7:0]                    master_aw_len,
    output logic [2:0]                    master_aw_size,
    output logic [1:0]                    master_aw_burst,
    output logic                          master_aw_valid,
    input  logic                          master_aw_ready,
    output logic [AXI_DATA_WIDTH-1:0]     master_w_data,
    output logic [AXI_DATA_WIDTH/8-1:0]   master_w_strb,
    output logic                          master_w_last,
    output logic                          master_w_valid,
    input  logic                          master_w_ready,
    input  logic [ID_WIDTH-1:0]           master_b_id,
    input  logic [1:0]                    master_b_resp,
    input  logic                          master_b_valid,
    output logic                          master_b_ready,
    output logic [ID_WIDTH-1:0]           master_ar_id,
    output logic [AXI_ADDR_WIDTH-1:0]     master_ar_addr,
    output logic [7:0]                    master_ar_len,
    output logic [2:0]                    master_ar_size,
    output logic [1:0]                    master_ar_burst,
    output logic                          master_ar_valid,
    input  logic                          master_ar_ready,
    input  logic [ID_WIDTH-1:0]           master_r_id,
    input  logic [AXI_DATA_WIDTH-1:0]     master_r_data,
    input  logic [1:0]                    master_r_resp,
    input  logic                          master_r_last,
    input  logic                          master_r_valid,
    output logic                          master_r_ready
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int OFFS = $clog2(STRB_W);
    localparam logic [2:0] SIZE = 3'(OFFS);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK =
        {AXI_ADDR_WIDTH{1'b1}} << OFFS;
    localparam logic [ID_WIDTH-1:0] ID = ID_WIDTH'(AXI_ID);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WR     = 3'd1;
    localparam logic [2:0] WAIT_B = 3'd2;
    localparam logic [2:0] RD     = 3'd3;
    localparam logic [2:0] WAIT_R = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0] state_q, state_d;
    logic aw_valid_q, aw_valid_d;
    logic w_valid_q, w_valid_d;
    logic b_ready_q, b_ready_d;
    logic ar_valid_q, ar_valid_d;
    logic r_ready_q, r_ready_d;
    logic ack_q, ack_d;
    logic err_q, err_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    // r_last carries no information for single-beat reads
    logic unused_r_last;
    assign unused_r_last = master_r_last;

    always_comb begin
        state_d    = state_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        b_ready_d  = b_ready_q;
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    addr_d  = wb_adr_i & ADDR_MASK;
                    wdata_d = wb_dat_i;
                    strb_d  = wb_sel_i;
                    if (wb_we_i) begin
                        state_d    = WR;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = RD;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            WR: begin
                if (aw_valid_q && master_aw_ready) aw_valid_d = 1'b0;
                if (w_valid_q && master_w_ready) w_valid_d = 1'b0;
                if (!aw_valid_d && !w_valid_d) begin
                    state_d   = WAIT_B;
                    b_ready_d = 1'b1;
                end
            end
            WAIT_B: begin
                if (master_b_valid) begin
                    state_d   = DONE;
                    b_ready_d = 1'b0;
                    // a master that already left the cycle gets no termination
                    if (master_b_resp[1] || master_b_id != ID) err_d = wb_cyc_i;
                    else ack_d = wb_cyc_i;
                end
            end
            RD: begin
                if (master_ar_ready) begin
                    state_d    = WAIT_R;
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            WAIT_R: begin
                if (master_r_valid) begin
                    state_d   = DONE;
                    r_ready_d = 1'b0;
                    rdata_d   = master_r_data;
                    if (master_r_resp[1] || master_r_id != ID) err_d = wb_cyc_i;
                    else ack_d = wb_cyc_i;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            b_ready_q  <= b_ready_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            rdata_q    <= rdata_d;
        end
    end

    assign wb_dat_o        = rdata_q;
    assign wb_ack_o        = ack_q;
    assign wb_err_o        = err_q;
    assign master_aw_id    = ID;
    assign master_aw_addr  = addr_q;
    assign master_aw_len   = 8'd0;
    assign master_aw_size  = SIZE;
    assign master_aw_burst = 2'b01;
    assign master_aw_valid = aw_valid_q;
    assign master_w_data   = wdata_q;
    assign master_w_strb   = strb_q;
    assign master_w_last   = 1'b1;
    assign master_w_valid  = w_valid_q;
    assign master_b_ready  = b_ready_q;
    assign master_ar_id    = ID;
    assign master_ar_addr  = addr_q;
    assign master_ar_len   = 8'd0;
    assign master_ar_size  = SIZE;
    assign master_ar_burst = 2'b01;
    assign master_ar_valid = ar_valid_q;
    assign master_r_ready  = r_ready_q;

endmodule
